// File: rtl/wb_burst_arb.sv
// Burst-holding 4-way arbiter for a wishbone slave port; grant is registered (1-cycle latency).
// An owner keeps the port until last-ack, request drop or stall watchdog; a 1-cycle REL gap follows.
module wb_burst_arb #(
  parameter int NREQ   = 4,
  parameter int HOLD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              cfg_arb_mode,
  input  logic [HOLD_W-1:0] cfg_hold_max,
  input  logic [NREQ-1:0]   req_i,
  input  logic              ack_i,
  input  logic              lack_i,
  output logic [1:0]        gnt_o,
  output logic              gnt_vld_o,
  output logic [NREQ-1:0]   gnt_oh_o,
  output logic              hold_timeout_o,
  output logic [1:0]        rr_ptr_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              vld_q, vld_d;
  logic [NREQ-1:0]   oh_q, oh_d;
  logic              to_q, to_d;
  logic [1:0]        rr_q, rr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic [1:0] rr_win, fp_win, idx;
  logic       rr_hit, wd_hit;

  // Round-robin scans from rr_q upward (mod 4); fixed priority takes the lowest index.
  always_comb begin
    rr_win = 2'd0;
    rr_hit = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      idx = rr_q + 2'(i);
      if (!rr_hit && req_i[idx]) begin
        rr_win = idx;
        rr_hit = 1'b1;
      end
    end
    fp_win = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) fp_win = 2'(i);
    end
  end

  assign wd_hit = (cfg_hold_max != '0) && (cnt_q == cfg_hold_max - HOLD_W'(1)) && !ack_i;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vld_d   = 1'b0;
    to_d    = 1'b0;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i != '0) begin
          state_d = ST_OWN;
          gnt_d   = cfg_arb_mode ? fp_win : rr_win;
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        // Last-ack takes precedence over a coincident watchdog expiry.
        if (lack_i || !req_i[gnt_q] || wd_hit) begin
          state_d = ST_REL;
          to_d    = wd_hit && !lack_i;
        end else begin
          vld_d = 1'b1;
          if (ack_i)       cnt_d = '0;
          else if (~&cnt_q) cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
        rr_d    = gnt_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    oh_d = vld_d ? (NREQ'(1) << gnt_d) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'd0;
      vld_q   <= 1'b0;
      oh_q    <= '0;
      to_q    <= 1'b0;
      rr_q    <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      oh_q    <= oh_d;
      to_q    <= to_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o          = gnt_q;
  assign gnt_vld_o      = vld_q;
  assign gnt_oh_o       = oh_q;
  assign hold_timeout_o = to_q;
  assign rr_ptr_o       = rr_q;

endmodule

// File: tb/tb_wb_burst_arb.sv
// Directed bench for wb_burst_arb: expected grant owners are queued as requests are driven
// and popped when a grant appears; all other expectations are written inline.
module tb_wb_burst_arb;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic       cfg_arb_mode;
  logic [7:0] cfg_hold_max;
  logic [3:0] req_i;
  logic       ack_i;
  logic       lack_i;
  logic [1:0] gnt_o;
  logic       gnt_vld_o;
  logic [3:0] gnt_oh_o;
  logic       hold_timeout_o;
  logic [1:0] rr_ptr_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  wb_burst_arb #(.NREQ(4), .HOLD_W(8)) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .cfg_arb_mode   (cfg_arb_mode),
    .cfg_hold_max   (cfg_hold_max),
    .req_i          (req_i),
    .ack_i          (ack_i),
    .lack_i         (lack_i),
    .gnt_o          (gnt_o),
    .gnt_vld_o      (gnt_vld_o),
    .gnt_oh_o       (gnt_oh_o),
    .hold_timeout_o (hold_timeout_o),
    .rr_ptr_o       (rr_ptr_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Compare the current grant against the oldest queued expectation.
  task automatic pop_gnt(input string tag);
    logic [1:0] e;
    logic [3:0] oh_e;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s scoreboard empty observed gnt=%0d", tag, gnt_o);
    end
    if (exp_q.size() != 0) begin
      e    = exp_q.pop_front();
      oh_e = 4'b0001 << e;
      chk({tag, ".vld"}, gnt_vld_o, 1);
      chk({tag, ".gnt"}, gnt_o, e);
      chk({tag, ".oh"}, gnt_oh_o, oh_e);
    end
  endtask

  // Drive one lack pulse, then check the REL and IDLE gap cycles.
  task automatic release_by_lack(input string tag);
    lack_i = 1'b1;
    tick();
    lack_i = 1'b0;
    chk({tag, ".rel_vld"}, gnt_vld_o, 0);
    chk({tag, ".rel_to"}, hold_timeout_o, 0);
    tick();
    chk({tag, ".idle_vld"}, gnt_vld_o, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic to_seen;
    rst_n        = 1'b0;
    cfg_arb_mode = 1'b0;
    cfg_hold_max = 8'd0;
    req_i        = 4'b0000;
    ack_i        = 1'b0;
    lack_i       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst.gnt", gnt_o, 0);
    chk("rst.vld", gnt_vld_o, 0);
    chk("rst.oh", gnt_oh_o, 0);
    chk("rst.to", hold_timeout_o, 0);
    chk("rst.rr", rr_ptr_o, 0);
    tick();
    chk("idle.novld", gnt_vld_o, 0);

    // Single requester, 4-beat burst ending in lack, then re-grant.
    req_i = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    pop_gnt("single.grant");
    ack_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("single.beat_vld", gnt_vld_o, 1);
    end
    ack_i = 1'b1;
    release_by_lack("single");
    ack_i = 1'b0;
    chk("single.rr", rr_ptr_o, 3);
    exp_q.push_back(2'd2);
    tick();
    pop_gnt("single.regrant");

    // Asynchronous reset in the middle of an owned cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.vld", gnt_vld_o, 0);
    chk("arst.gnt", gnt_o, 0);
    chk("arst.rr", rr_ptr_o, 0);
    chk("arst.oh", gnt_oh_o, 0);
    req_i = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();

    // Round-robin fairness with all four requesting.
    req_i = 4'b1111;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      pop_gnt("rr.grant");
      if (k == 4) req_i = 4'b0000;
      release_by_lack("rr");
    end
    chk("rr.ptr_end", rr_ptr_o, 1);

    // Fixed priority starves master 3 until mode returns to round-robin.
    cfg_arb_mode = 1'b1;
    req_i = 4'b1010;
    exp_q.push_back(2'd1);
    tick();
    pop_gnt("fix.first");
    release_by_lack("fix.a");
    chk("fix.rr", rr_ptr_o, 2);
    exp_q.push_back(2'd1);
    tick();
    pop_gnt("fix.second");
    release_by_lack("fix.b");
    cfg_arb_mode = 1'b0;
    exp_q.push_back(2'd3);
    tick();
    pop_gnt("fix.rr_switch");
    req_i = 4'b0000;
    release_by_lack("fix.c");

    // Burst hold: a competing request mid-burst does not preempt.
    req_i = 4'b0001;
    exp_q.push_back(2'd0);
    tick();
    pop_gnt("hold.grant");
    ack_i = 1'b1;
    for (int b = 1; b < 8; b++) begin
      if (b == 3) req_i = 4'b0011;
      tick();
      chk("hold.owner", gnt_o, 0);
      chk("hold.vld", gnt_vld_o, 1);
    end
    release_by_lack("hold");
    ack_i = 1'b0;
    exp_q.push_back(2'd1);
    tick();
    pop_gnt("hold.next");
    req_i = 4'b0000;
    release_by_lack("hold.b");

    // Watchdog expiry after 5 ack-less owned cycles.
    cfg_hold_max = 8'd5;
    req_i = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    pop_gnt("wd.grant");
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("wd.pre_vld", gnt_vld_o, 1);
      chk("wd.pre_to", hold_timeout_o, 0);
    end
    tick();
    req_i = 4'b0000;
    chk("wd.rel_vld", gnt_vld_o, 0);
    chk("wd.pulse", hold_timeout_o, 1);
    chk("wd.rel_gnt", gnt_o, 2);
    tick();
    chk("wd.pulse_end", hold_timeout_o, 0);

    // Ack on cycle 3 restarts the count; lack coinciding with expiry wins.
    req_i = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    pop_gnt("wdack.grant");
    tick();
    tick();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("wdack.vld", gnt_vld_o, 1);
      chk("wdack.to", hold_timeout_o, 0);
      tick();
    end
    chk("wdack.still_vld", gnt_vld_o, 1);
    req_i = 4'b0000;
    release_by_lack("wdack");

    // Watchdog disabled: long stall never times out; then abort.
    cfg_hold_max = 8'd0;
    req_i = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    pop_gnt("wdoff.grant");
    to_seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (hold_timeout_o || !gnt_vld_o) to_seen = 1'b1;
    end
    chk("wdoff.no_timeout", to_seen, 0);
    req_i = 4'b0000;
    tick();
    chk("abort.vld", gnt_vld_o, 0);
    chk("abort.to", hold_timeout_o, 0);
    chk("abort.gnt_kept", gnt_o, 2);
    tick();
    chk("abort.idle_vld", gnt_vld_o, 0);
    chk("abort.rr", rr_ptr_o, 3);

    chk("sb.empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_burst_arb.md
Name: wb_burst_arb

Overview:
- Burst-aware 4-requester arbiter for a wishbone slave port; drives the grant select of the port's master mux and read-return demux.
- Holds grant for a whole burst until last-ack (lack) or request withdrawal.
- Round-robin or fixed-priority selection.
- Watchdog forcibly releases an owner that stalls without acks.

Parameters:
- NREQ, 4, number of requesters (fixed at 4; grant index is 2 bits)
- HOLD_W, 8, width of the stall watchdog counter and of cfg_hold_max

Ports:
- clk_i  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- cfg_arb_mode  input  1  0 = round-robin, 1 = fixed priority (req_i[0] highest)
- cfg_hold_max  input  HOLD_W  max consecutive ack-less owned cycles; 0 disables the watchdog
- req_i  input  4  per-master request (stb qualified by target id, lack-masked)
- ack_i  input  1  ack returned on the granted path
- lack_i  input  1  last-ack of burst on the granted path
- gnt_o  output  2  index of current or last owner
- gnt_vld_o  output  1  grant active, in OWN state
- gnt_oh_o  output  4  one-hot of gnt_o, qualified by gnt_vld_o
- hold_timeout_o  output  1  one-cycle pulse on watchdog release
- rr_ptr_o  output  2  current round-robin search start, for debug

Behaviour:
- Reset values: gnt_o=0, gnt_vld_o=0, gnt_oh_o=0, hold_timeout_o=0, rr_ptr_o=0, state=IDLE, hold counter=0.
- States are IDLE, OWN, REL. All outputs are registered.
- IDLE:
  - If req_i != 0, select a winner and register it into gnt_o; next state OWN.
  - gnt_vld_o rises the cycle after req_i is sampled (1-cycle grant latency).
  - If req_i == 0, stay in IDLE; gnt_o holds its last value.
- Winner selection:
  - Round-robin: first set bit of req_i scanning rr_ptr, rr_ptr+1, ... modulo 4.
  - Fixed: lowest set index.
- OWN:
  - Exit to REL when any of these holds: lack_i=1; req_i[gnt_o]=0 (abort); or watchdog expiry.
  - Otherwise stay in OWN.
  - Other requests never preempt.
  - ack_i without lack_i keeps ownership.
- Watchdog:
  - Hold counter clears on OWN entry and on every ack_i.
  - Increments on each OWN cycle without ack_i, saturating at all-ones.
  - When cfg_hold_max != 0 and counter == cfg_hold_max-1 with no ack_i that cycle: next state REL, hold_timeout_o=1 for exactly one cycle.
- REL:
  - Lasts exactly 1 cycle; gnt_vld_o=0, gnt_o unchanged so the slave-side staging stage drains to the old owner.
  - rr_ptr updates to (gnt_o+1) mod 4 in both modes.
  - Next state IDLE, so a new grant is valid no earlier than 2 cycles after the release condition.
- Simultaneous events:
  - lack_i together with req drop, or with watchdog expiry: single release; hold_timeout_o=0, since lack wins.
- Ignored inputs:
  - ack_i/lack_i in IDLE or REL are ignored.
  - Requests appearing during REL are arbitrated in IDLE next cycle.
- Config timing:
  - cfg_arb_mode/cfg_hold_max changes take effect at the next IDLE selection or next counter compare; there is no mid-grant effect on the current owner.
- gnt_oh_o = gnt_vld_o ? (1<<gnt_o) : 0.
- Async reset mid-burst returns all state to reset values immediately; on release, the first selection starts from index 0.

Test Plan:
- Single requester: req_i=4'b0100 from reset -> gnt_o=2, gnt_vld_o=1 one cycle later. Then 3 acks plus lack on the 4th -> REL one cycle, IDLE, re-grant to 2 if still requesting, rr_ptr_o=3.
- Round-robin fairness: req_i=4'b1111 held, each owner ends with a single lack -> grant sequence 0,1,2,3,0; each grant separated by REL+IDLE (2 cycles with gnt_vld_o=0).
- Fixed priority: cfg_arb_mode=1, req_i=4'b1010 -> 1 granted; after lack, with req_i=4'b1010 -> 1 again, master 3 starves; switch to mode 0 -> 3 granted next.
- Burst hold: owner 0 in 8-beat burst, req_i[1] asserted mid-burst -> gnt_o stays 0 until lack; grant to 1 follows.
- Watchdog: cfg_hold_max=5, owner 2, no ack -> hold_timeout_o pulses on the 5th ack-less cycle's successor edge, REL entered. Repeat with ack_i on cycle 3 -> counter restarts, no timeout before lack. Repeat with cfg_hold_max=0 -> never times out.
- Abort/reset: req_i[gnt_o] drops mid-burst -> REL next cycle without hold_timeout_o. Assert rst_n low mid-OWN -> gnt_vld_o=0, gnt_o=0, rr_ptr_o=0 asynchronously.
